// File: rtl/icache_ctrl_if.sv
// Fetch-side and refill-side signal bundle for icache_ctrl.
// The slave modport is the cache; the master modport is the core plus instruction memory.
interface icache_ctrl_if #(
   parameter int ADDR_W = 32
) ();
   logic [ADDR_W-1:0] PC;
   logic              FETCH;
   logic              FLUSH;
   logic [31:0]       IR;
   logic              IR_VALID;
   logic              STALL;
   logic              MEM_REQ;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [31:0]       MEM_RDATA;
   logic              MEM_RVALID;

   modport master (
      output PC, FETCH, FLUSH, MEM_RDATA, MEM_RVALID,
      input  IR, IR_VALID, STALL, MEM_REQ, MEM_ADDR
   );

   modport slave (
      input  PC, FETCH, FLUSH, MEM_RDATA, MEM_RVALID,
      output IR, IR_VALID, STALL, MEM_REQ, MEM_ADDR
   );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with word-serial refill FSM and whole-cache flush.
// Define ICACHE_PERF_EN to add saturating hit/miss/stall counters.
module icache_ctrl #(
   parameter int LINE_WORDS = 8,
   parameter int NUM_LINES  = 16,
   parameter int ADDR_W     = 32
) (
   input  logic         CLK,
   input  logic         RST_N,
   icache_ctrl_if.slave bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]  HIT_CNT,
   output logic [31:0]  MISS_CNT,
   output logic [31:0]  STALL_CNT
`endif
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

   state_t             state, state_nxt;
   logic [OFF_W-1:0]   pc_off, beat;
   logic [IDX_W-1:0]   pc_idx, miss_idx;
   logic [TAG_W-1:0]   pc_tag, miss_tag;
   logic [1:0]         unused_pc_bits;
   logic [NUM_LINES-1:0] valid;
   logic               flush_pending;
   logic               hit;
   logic               last_beat;

   logic [31:0]        data_mem [NUM_LINES*LINE_WORDS];
   logic [TAG_W-1:0]   tag_mem  [NUM_LINES];

   assign {pc_tag, pc_idx, pc_off} = bus.PC[ADDR_W-1:2];
   assign unused_pc_bits = bus.PC[1:0];
   assign last_beat      = (beat == OFF_W'(LINE_WORDS - 1));

   // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt    = state;
      hit          = bus.FETCH && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag) && (state == IDLE);
      bus.IR       = '0;
      bus.IR_VALID = hit;
      bus.STALL    = (bus.FETCH && !hit) || (state != IDLE);
      bus.MEM_REQ  = 1'b0;
      bus.MEM_ADDR = '0;

      if (hit) bus.IR = data_mem[{pc_idx, pc_off}];

      case (state)
         IDLE: begin
            if (bus.FETCH && !hit) state_nxt = REFILL;
         end
         REFILL: begin
            bus.MEM_REQ  = 1'b1;
            bus.MEM_ADDR = {miss_tag, miss_idx, beat, 2'b00};
            if (bus.MEM_RVALID && last_beat) state_nxt = FILL_DONE;
         end
         FILL_DONE: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid         <= '0;
         beat          <= '0;
         miss_tag      <= '0;
         miss_idx      <= '0;
         flush_pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.FLUSH) valid <= '0;
               if (state_nxt == REFILL) begin
                  miss_tag <= pc_tag;
                  miss_idx <= pc_idx;
                  beat     <= '0;
               end
            end
            REFILL: begin
               if (bus.FLUSH) flush_pending <= 1'b1;
               if (bus.MEM_RVALID) beat <= last_beat ? '0 : beat + 1'b1;
            end
            FILL_DONE: begin
               flush_pending <= 1'b0;
               // A flush seen at any point during the refill discards the new line too.
               if (flush_pending || bus.FLUSH) valid <= '0;
               else                            valid[miss_idx] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: storage arrays carry no reset; the valid bits alone make their contents meaningful.
   always_ff @(posedge CLK) begin
      if (state == REFILL && bus.MEM_RVALID) data_mem[{miss_idx, beat}] <= bus.MEM_RDATA;
      if (state == FILL_DONE)                tag_mem[miss_idx]          <= miss_tag;
   end

`ifdef ICACHE_PERF_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         HIT_CNT   <= '0;
         MISS_CNT  <= '0;
         STALL_CNT <= '0;
      end else begin
         if (hit && HIT_CNT != 32'hFFFF_FFFF) HIT_CNT <= HIT_CNT + 1'b1;
         if (state == IDLE && state_nxt == REFILL && MISS_CNT != 32'hFFFF_FFFF)
            MISS_CNT <= MISS_CNT + 1'b1;
         if (bus.STALL && STALL_CNT != 32'hFFFF_FFFF) STALL_CNT <= STALL_CNT + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl at default geometry (8 words x 16 lines).
// Inputs change and outputs are sampled just after the falling edge.
module tb_icache_ctrl;
   logic CLK = 1'b0;
   logic RST_N;
   int   checks = 0;
   int   errors = 0;

   icache_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt, stall_cnt;
`endif

   icache_ctrl #(.LINE_WORDS(8), .NUM_LINES(16), .ADDR_W(32)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
`ifdef ICACHE_PERF_EN
      ,
      .HIT_CNT   (hit_cnt),
      .MISS_CNT  (miss_cnt),
      .STALL_CNT (stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Starts a fetch that must miss, then plays the memory for the whole refill.
   task automatic do_miss(input logic [31:0] pc, input logic [31:0] base, input int hold_beat,
                          input int hold_n, input int flush_beat, output int stalls);
      int          exp_beat;
      int          held;
      logic [31:0] exp_addr;
      exp_beat = 0;
      held     = 0;
      stalls   = 0;
      @(negedge CLK);
      bus.PC = pc; bus.FETCH = 1'b1; bus.FLUSH = 1'b0; bus.MEM_RVALID = 1'b0;
      #1;
      checks++;
      if (bus.STALL !== 1'b1 || bus.IR_VALID !== 1'b0) begin
         errors++;
         $display("FAIL miss_detect pc=%h: stall=%b ir_valid=%b, want stall=1 ir_valid=0",
                  pc, bus.STALL, bus.IR_VALID);
      end
      stalls = 1;
      for (int c = 0; c < 40 && exp_beat < 8; c++) begin
         @(negedge CLK);
         bus.MEM_RVALID = 1'b0; bus.FLUSH = 1'b0;
         #1;
         exp_addr = (pc & ~32'h1F) | (32'(exp_beat) << 2);
         checks++;
         if (bus.MEM_REQ !== 1'b1 || bus.STALL !== 1'b1) begin
            errors++;
            $display("FAIL refill_req beat=%0d: req=%b stall=%b, want 1 1", exp_beat, bus.MEM_REQ, bus.STALL);
         end
         checks++;
         if (bus.MEM_ADDR !== exp_addr) begin
            errors++;
            $display("FAIL refill_addr beat=%0d: got %h want %h", exp_beat, bus.MEM_ADDR, exp_addr);
         end
         stalls++;
         if (exp_beat == hold_beat && held < hold_n) begin
            held++;
            bus.MEM_RDATA = 32'hDEAD_BEEF;
         end else begin
            bus.MEM_RVALID = 1'b1;
            bus.MEM_RDATA  = base + 32'(exp_beat);
            if (exp_beat == flush_beat) bus.FLUSH = 1'b1;
            exp_beat++;
         end
      end
      checks++;
      if (exp_beat != 8) begin
         errors++;
         $display("FAIL refill_timeout: beats done %0d, want 8", exp_beat);
      end
      // FILL_DONE: stray data offered while no request is pending must be ignored.
      @(negedge CLK);
      bus.FLUSH = 1'b0; bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (bus.MEM_REQ !== 1'b0 || bus.STALL !== 1'b1) begin
         errors++;
         $display("FAIL fill_done: req=%b stall=%b, want req=0 stall=1", bus.MEM_REQ, bus.STALL);
      end
      stalls++;
   endtask

   task automatic check_hit(input logic [31:0] pc, input logic [31:0] exp_ir);
      @(negedge CLK);
      bus.PC = pc; bus.FETCH = 1'b1; bus.FLUSH = 1'b0; bus.MEM_RVALID = 1'b0;
      #1;
      checks++;
      if (bus.IR_VALID !== 1'b1 || bus.STALL !== 1'b0) begin
         errors++;
         $display("FAIL hit_flags pc=%h: ir_valid=%b stall=%b, want 1 0", pc, bus.IR_VALID, bus.STALL);
      end
      checks++;
      if (bus.IR !== exp_ir) begin
         errors++;
         $display("FAIL hit_data pc=%h: got %h want %h", pc, bus.IR, exp_ir);
      end
   endtask

   task automatic flush_idle();
      @(negedge CLK);
      bus.FETCH = 1'b0; bus.FLUSH = 1'b1; bus.MEM_RVALID = 1'b0;
      #1;
      checks++;
      if (bus.STALL !== 1'b0 || bus.MEM_REQ !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: stall=%b req=%b, want 0 0", bus.STALL, bus.MEM_REQ);
      end
   endtask

   task automatic check_stalls(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: stall cycles %0d, want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      bus.PC = 32'h0; bus.FETCH = 1'b0; bus.FLUSH = 1'b0;
      bus.MEM_RDATA = 32'h0; bus.MEM_RVALID = 1'b0;
      #12;
      checks++;
      if (bus.MEM_REQ !== 1'b0 || bus.MEM_ADDR !== 32'h0 || bus.IR_VALID !== 1'b0 ||
          bus.IR !== 32'h0 || bus.STALL !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b addr=%h ir_valid=%b ir=%h stall=%b, want all 0",
                  bus.MEM_REQ, bus.MEM_ADDR, bus.IR_VALID, bus.IR, bus.STALL);
      end
      bus.FETCH = 1'b1;
      #1;
      checks++;
      if (bus.STALL !== 1'b1 || bus.IR_VALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_fetch: stall=%b ir_valid=%b, want 1 0", bus.STALL, bus.IR_VALID);
      end
      bus.FETCH = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_cold_miss();
      int st;
      do_miss(32'h40, 32'h1000, -1, 0, -1, st);
      check_stalls("cold_miss_stall", st, 10);
      check_hit(32'h40, 32'h1000);
      for (int i = 1; i < 8; i++) check_hit(32'h40 + 32'(4 * i), 32'h1000 + 32'(i));
`ifdef ICACHE_PERF_EN
      @(negedge CLK);
      bus.FETCH = 1'b0;
      #1;
      checks++;
      if (hit_cnt !== 32'd8 || miss_cnt !== 32'd1 || stall_cnt !== 32'd10) begin
         errors++;
         $display("FAIL perf_counters: hit=%0d miss=%0d stall=%0d, want 8 1 10", hit_cnt, miss_cnt, stall_cnt);
      end
`endif
   endtask

   task automatic test_conflict();
      int st;
      do_miss(32'h240, 32'h2000, -1, 0, -1, st);
      check_stalls("conflict_stall", st, 10);
      check_hit(32'h240, 32'h2000);
      check_hit(32'h25C, 32'h2007);
      do_miss(32'h40, 32'h1100, -1, 0, -1, st);
      check_hit(32'h40, 32'h1100);
   endtask

   task automatic test_flush();
      int st;
      flush_idle();
      do_miss(32'h40, 32'h3000, -1, 0, 2, st);
      do_miss(32'h40, 32'h4000, -1, 0, -1, st);
      check_hit(32'h44, 32'h4001);
   endtask

   task automatic test_stalled_memory();
      int st;
      flush_idle();
      do_miss(32'h40, 32'h5000, 3, 5, -1, st);
      check_stalls("stalled_mem_stall", st, 15);
      check_hit(32'h4C, 32'h5003);
      check_hit(32'h48, 32'h5002);
   endtask

   task automatic test_async_reset();
      int st;
      @(negedge CLK);
      bus.PC = 32'h80; bus.FETCH = 1'b1; bus.FLUSH = 1'b0; bus.MEM_RVALID = 1'b0;
      for (int b = 0; b < 4; b++) begin
         @(negedge CLK);
         bus.MEM_RVALID = 1'b1;
         bus.MEM_RDATA  = 32'h7000 + 32'(b);
      end
      @(negedge CLK);
      bus.MEM_RVALID = 1'b0;
      #1;
      checks++;
      if (bus.MEM_REQ !== 1'b1 || bus.MEM_ADDR !== 32'h90) begin
         errors++;
         $display("FAIL beat4_addr: req=%b addr=%h, want 1 00000090", bus.MEM_REQ, bus.MEM_ADDR);
      end
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if (bus.MEM_REQ !== 1'b0 || bus.MEM_ADDR !== 32'h0 || bus.STALL !== 1'b1 || bus.IR_VALID !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: req=%b addr=%h stall=%b ir_valid=%b, want 0 0 1 0",
                  bus.MEM_REQ, bus.MEM_ADDR, bus.STALL, bus.IR_VALID);
      end
      @(negedge CLK);
      bus.FETCH = 1'b0;
      RST_N = 1'b1;
      do_miss(32'h40, 32'h6000, -1, 0, -1, st);
      check_stalls("post_reset_stall", st, 10);
      check_hit(32'h40, 32'h6000);
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_conflict();
      test_flush();
      test_stalled_memory();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Parametrised direct-mapped instruction cache with its own refill state machine.
- Sits in the IF stage between the PC and a word-serial instruction memory port.
- Replaces the fixed 8-word-line cache and hit/miss FSM pair.
- Adds configurable geometry, a request/valid refill handshake, whole-cache invalidate, and an optional performance counter block.

Parameters:
- LINE_WORDS, 8, 32-bit words per line; power of 2, >= 2.
- NUM_LINES, 16, lines in the cache; power of 2, >= 2.
- ADDR_W, 32, byte-address width of PC and MEM_ADDR.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- PC  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- FETCH  in  1  fetch request this cycle.
- FLUSH  in  1  invalidate entire cache (FENCE.I / self-modifying code).
- IR  out  32  instruction word; valid only when IR_VALID=1.
- IR_VALID  out  1  hit this cycle.
- STALL  out  1  freeze PC / IF-DE register.
- MEM_REQ  out  1  refill beat request.
- MEM_ADDR  out  ADDR_W  word-aligned refill beat address.
- MEM_RDATA  in  32  refill data.
- MEM_RVALID  in  1  MEM_RDATA valid; completes current beat.

Behaviour:
- Address split:
  - offset = PC[1+log2(LINE_WORDS):2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Storage: data array NUM_LINES x LINE_WORDS x 32; tag array; valid bit per line.
- Lookup is combinational. hit = FETCH & valid[index] & (tag match) & state==IDLE.
  - IR = data[index][offset] when hit; IR = 0 otherwise.
- IR_VALID = hit.
- STALL = FETCH & ~hit, or state != IDLE. Asserted in the same cycle as the miss.
- States:
  - IDLE
    - miss -> REFILL: latch miss tag/index, beat counter = 0.
    - FLUSH asserted -> all valid bits cleared at next edge; stay IDLE.
  - REFILL
    - MEM_REQ = 1; MEM_ADDR = {tag, index, beat, 2'b00}.
    - On each MEM_RVALID: write MEM_RDATA into data[index][beat], beat++.
    - MEM_REQ/MEM_ADDR hold stable until MEM_RVALID. MEM_RVALID while MEM_REQ=0 is ignored.
    - MEM_RVALID on beat LINE_WORDS-1 -> FILL_DONE.
  - FILL_DONE
    - Write tag; set valid[index] unless flush_pending.
    - Clear flush_pending (and, if set, clear all valid bits) -> IDLE.
    - Refetch hits on the following cycle if the line is still valid.
- FLUSH during REFILL or FILL_DONE: set flush_pending; refill completes; the refilled line is not validated.
- Miss latency: 1 + LINE_WORDS x (memory beat latency) + 1 cycles of STALL, then 1 hit cycle.
- FETCH deasserted in REFILL: refill still completes. No abort other than reset.
- Beat counter wraps only via the FILL_DONE transition; it never exceeds LINE_WORDS-1.
- Reset (async, any state, including mid-refill):
  - state=IDLE, all valid=0, beat=0, flush_pending=0.
  - MEM_REQ=0, MEM_ADDR=0, IR_VALID=0, IR=0.
  - STALL=FETCH (a fetch after reset misses).
  - Data and tag arrays are not reset.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined:
  - Adds outputs HIT_CNT[31:0], MISS_CNT[31:0], STALL_CNT[31:0], all reset to 0.
  - HIT_CNT increments on each hit cycle.
  - MISS_CNT increments on each IDLE->REFILL transition.
  - STALL_CNT increments on each cycle STALL=1.
  - Counters saturate at 32'hFFFF_FFFF and are not cleared by FLUSH.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Cold miss: after reset, FETCH=1, PC=0x0000_0040, memory returns 0x1000+i on beat i with 1-cycle latency.
  - MEM_ADDR steps 0x40..0x5C, STALL held 10 cycles.
  - Next cycle IR=0x1000, IR_VALID=1.
  - Then PC=0x44..0x5C all hit with IR=0x1001..0x1007, STALL=0.
- Conflict: PC=0x40 filled, then PC=0x0000_0240 (same index, defaults) -> miss, refill. Back to PC=0x40 -> miss again.
- Stalled memory: hold MEM_RVALID low 5 cycles on beat 3 -> MEM_ADDR stays 0x4C and MEM_REQ stays 1 for those cycles; no data written.
- Flush mid-refill: FLUSH pulse on beat 2 -> refill finishes, then FETCH PC=0x40 misses again. FLUSH in IDLE after a fill -> next fetch misses.
- Async reset: drop RST_N during beat 4 of refill -> MEM_REQ=0 immediately, state IDLE. After release, PC=0x40 misses (valid cleared).
- ICACHE_PERF_EN: after the cold-miss scenario plus 7 hits -> HIT_CNT=8, MISS_CNT=1, STALL_CNT=10.
